// File: rtl/buffered_join_if.sv
// buffered_join_if
//   Bundles the handshake signals of the buffered join: NumInputs valid/bp
//   producer lanes on one side and a single joined valid/bp output channel on
//   the other.
//
//   Handshake: a lane token is transferred on a rising clock edge when its
//   valid is 1 and its bp is 0. The joined token is transferred when
//   dout_valid is 1 and dout_bp is 0. bp = 1 means "not accepting".
//
//   Signals (lane i occupies bits [i*Width +: Width]):
//     din        producer lane data
//     din_valid  per-lane valid
//     din_bp     per-lane backpressure back to the producers
//     dout       joined token, lane i at [i*Width +: Width]
//     dout_valid joined token valid
//     dout_bp    consumer backpressure
//
//   Modports:
//     slave  - the join itself (consumes din, produces dout)
//     master - the environment (drives din and dout_bp)
interface buffered_join_if #(
    parameter int Width     = 8,
    parameter int NumInputs = 4
);
    logic [NumInputs*Width-1:0] din;
    logic [NumInputs-1:0]       din_valid;
    logic [NumInputs-1:0]       din_bp;
    logic [NumInputs*Width-1:0] dout;
    logic                       dout_valid;
    logic                       dout_bp;

    modport slave (
        input  din,
        input  din_valid,
        output din_bp,
        output dout,
        output dout_valid,
        input  dout_bp
    );

    modport master (
        output din,
        output din_valid,
        input  din_bp,
        input  dout,
        input  dout_valid,
        output dout_bp
    );
endinterface

// File: rtl/buffered_join.sv
// buffered_join
//   Synchronises NumInputs independent producer lanes into one consumer.
//   Every lane owns a one-entry holding buffer, so lanes that arrive at
//   different times are parked until the last one shows up. The joined token
//   is the concatenation of one token per lane. The last arriving lane (and
//   any lane not yet held) is bypassed combinationally, so an aligned set of
//   lanes passes through in zero cycles at one token per cycle.
//
//   Ports:
//     clk    clock; all state updates on the rising edge
//     reset  synchronous, active-high; clears all held flags and forces
//            din_bp to all-ones and dout_valid to 0 while asserted
//     bus    buffered_join_if.slave (din/din_valid/din_bp, dout/dout_valid/
//            dout_bp)
//     held   per-lane held flag, exposed for observation
//
//   Build option:
//     BUFFERED_JOIN_REFILL_EN  when defined, a held lane may load a new token
//       in the same cycle its old token is consumed (din_bp[i] =
//       held[i] & ~fire), removing the bubble after each fire at the cost of
//       a combinational path dout_bp -> din_bp. When undefined, din_bp is
//       driven purely from registers.
module buffered_join #(
    parameter int Width     = 8,
    parameter int NumInputs = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    buffered_join_if.slave       bus,
    output logic [NumInputs-1:0] held
);

    logic [NumInputs-1:0]       held_q;
    logic [Width-1:0]           buf_q [NumInputs];

    logic [NumInputs-1:0]       eff_valid;
    logic [NumInputs*Width-1:0] eff_data;
    logic                       join_valid;
    logic                       fire;

    // Each lane is presented either from its holding buffer or straight from
    // the input, whichever currently owns the lane's next token.
    always_comb begin
        eff_valid = held_q | bus.din_valid;
        eff_data  = '0;
        for (int i = 0; i < NumInputs; i++) begin
            eff_data[i*Width +: Width] = held_q[i] ? buf_q[i]
                                                   : bus.din[i*Width +: Width];
        end
    end

    // Reset gates the output combinationally so a partially gathered token
    // can never leak out while reset is asserted.
    assign join_valid     = ~reset & (&eff_valid);
    assign fire           = join_valid & ~bus.dout_bp;

    assign bus.dout       = eff_data;
    assign bus.dout_valid = join_valid;
    assign held           = held_q;

`ifdef BUFFERED_JOIN_REFILL_EN
    // A held lane reopens in the cycle its token leaves.
    assign bus.din_bp = reset ? {NumInputs{1'b1}} : (held_q & ~{NumInputs{fire}});
`else
    // Register-only backpressure: a lane stays closed for the whole cycle in
    // which its held token is consumed, costing one bubble per held lane.
    assign bus.din_bp = reset ? {NumInputs{1'b1}} : held_q;
`endif

    // Buffer contents are don't-care after reset, so only held_q is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q <= '0;
        end else begin
            for (int i = 0; i < NumInputs; i++) begin
                if (fire) begin
`ifdef BUFFERED_JOIN_REFILL_EN
                    // Drain and refill together when a held lane has a new
                    // token waiting; unheld lanes were consumed by bypass.
                    if (held_q[i] && bus.din_valid[i]) begin
                        held_q[i] <= 1'b1;
                        buf_q[i]  <= bus.din[i*Width +: Width];
                    end else begin
                        held_q[i] <= 1'b0;
                    end
`else
                    held_q[i] <= 1'b0;
`endif
                end else if (bus.din_valid[i] && !held_q[i]) begin
                    // Park a token that arrived before its partners. This
                    // also covers a complete set stalled by dout_bp, which
                    // keeps dout stable from the next edge on.
                    held_q[i] <= 1'b1;
                    buf_q[i]  <= bus.din[i*Width +: Width];
                end
            end
        end
    end

endmodule
